simple_core_frontend: RTL and testbench

- Front-end/datapath core of the 16-bit SIMPLE-style processor. It combines three parts:
  - a 5-phase one-hot phase counter;
  - the instruction register (IR), loaded from memory data in phase P1;
  - the ALU, which decodes the IR and operates on operands AR/BR, plus a registered condition-flag register.
- The surrounding controller supplies AR, BR and memory data, and consumes ir, phase, alu_out and flags.

---
 rtl/simple_core_frontend.sv | 131 +++++++++++++
 tb/tb_simple_core_frontend.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/simple_core_frontend.sv
// SIMPLE 16-bit processor front end: one-hot phase counter, instruction
// register, ALU with combinational flags, registered flags and halt latch.
module simple_core_frontend #(
    parameter int WIDTH = 16
) (
    input  logic             clock,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] mem_data,
    input  logic [WIDTH-1:0] ar,
    input  logic [WIDTH-1:0] br,
    input  logic [WIDTH-1:0] ext_in,
    output logic [4:0]       phase,
    output logic [WIDTH-1:0] ir,
    output logic [WIDTH-1:0] alu_out,
    output logic [3:0]       alu_flags,
    output logic [3:0]       flags,
    output logic             halted
);

    logic [4:0]       phase_q, phase_d;
    logic [WIDTH-1:0] ir_q, ir_d;
    logic [3:0]       flags_q, flags_d;
    logic             halted_q, halted_d;

    logic             alu_class;
    logic [3:0]       op;
    logic [3:0]       sh;
    logic             flag_op;

    logic [WIDTH:0]        sum_w;
    logic [WIDTH:0]        diff_w;
    logic [WIDTH:0]        sll_w;
    logic [WIDTH:0]        srl_w;
    logic signed [WIDTH:0] sra_w;
    logic [WIDTH-1:0]      rot_w;

    logic [WIDTH-1:0] res;
    logic             c_f;
    logic             v_f;

    assign alu_class = (ir_q[15:14] == 2'b11);
    assign op        = ir_q[7:4];
    assign sh        = ir_q[3:0];
    assign flag_op   = (op <= 4'd6) || (op[3:2] == 2'b10);

    assign sum_w  = {1'b0, ar} + {1'b0, br};
    assign diff_w = {1'b0, ar} - {1'b0, br};
    // Extra bit below/above the word catches the last bit shifted out.
    assign sll_w  = {1'b0, ar} << sh;
    assign srl_w  = {ar, 1'b0} >> sh;
    assign sra_w  = $signed({ar, 1'b0}) >>> sh;
    assign rot_w  = (ar << sh) | (ar >> (5'd16 - {1'b0, sh}));

    always_comb begin
        res = '0;
        c_f = 1'b0;
        v_f = 1'b0;
        if (!alu_class) begin
            res = sum_w[WIDTH-1:0];
        end else begin
            case (op)
                4'b0000: begin
                    res = sum_w[WIDTH-1:0];
                    c_f = sum_w[WIDTH];
                    v_f = (ar[15] == br[15]) && (sum_w[15] != ar[15]);
                end
                4'b0001, 4'b0101: begin
                    res = diff_w[WIDTH-1:0];
                    c_f = diff_w[WIDTH];
                    v_f = (ar[15] != br[15]) && (diff_w[15] != ar[15]);
                end
                4'b0010: res = ar & br;
                4'b0011: res = ar | br;
                4'b0100: res = ar ^ br;
                4'b0110: res = br;
                4'b1000: begin
                    res = sll_w[WIDTH-1:0];
                    c_f = sll_w[WIDTH];
                end
                4'b1001: begin
                    res = rot_w;
                    c_f = (sh != 4'd0) && rot_w[0];
                end
                4'b1010: begin
                    res = srl_w[WIDTH:1];
                    c_f = srl_w[0];
                end
                4'b1011: begin
                    res = sra_w[WIDTH:1];
                    c_f = sra_w[0];
                end
                4'b1100: res = ext_in;
                4'b1101: res = br;
                default: res = '0;
            endcase
        end
    end

    always_comb begin
        phase_d  = {phase_q[3:0], phase_q[4]};
        ir_d     = phase_q[0] ? mem_data : ir_q;
        flags_d  = flags_q;
        halted_d = halted_q;
        if (phase_q[2] && alu_class) begin
            if (flag_op) flags_d = alu_flags;
            if (op == 4'b1111) halted_d = 1'b1;
        end
    end

    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            phase_q  <= 5'b00001;
            ir_q     <= '0;
            flags_q  <= '0;
            halted_q <= 1'b0;
        end else begin
            phase_q  <= phase_d;
            ir_q     <= ir_d;
            flags_q  <= flags_d;
            halted_q <= halted_d;
        end
    end

    assign alu_out   = res;
    assign alu_flags = {v_f, c_f, (res == '0), res[15]};
    assign phase     = phase_q;
    assign ir        = ir_q;
    assign flags     = flags_q;
    assign halted    = halted_q;

endmodule

// File: tb/tb_simple_core_frontend.sv
// Scoreboard bench for simple_core_frontend: phase rotation, IR load,
// ALU results and flags, flag register holds, halt and async reset.
module tb_simple_core_frontend;

    logic        clock = 1'b0;
    logic        rst_n;
    logic [15:0] mem_data, ar, br, ext_in;
    logic [4:0]  phase;
    logic [15:0] ir, alu_out;
    logic [3:0]  alu_flags, flags;
    logic        halted;

    always #5 clock = ~clock;

    simple_core_frontend #(.WIDTH(16)) dut (
        .clock(clock), .rst_n(rst_n), .mem_data(mem_data),
        .ar(ar), .br(br), .ext_in(ext_in),
        .phase(phase), .ir(ir), .alu_out(alu_out),
        .alu_flags(alu_flags), .flags(flags), .halted(halted)
    );

    typedef struct packed {
        logic [15:0] val;
        logic [3:0]  flg;
    } exp_t;

    typedef struct {
        string       nm;
        logic [15:0] irv, a, b, e, val;
        logic [3:0]  flg;
        bit          upd;
    } vec_t;

    exp_t        sb[$];
    exp_t        ex;
    int          checks = 0;
    int          errors = 0;
    logic [3:0]  flag_m;

    task automatic goto_phase(input logic [4:0] p);
        int n = 0;
        while (phase !== p && n < 6) begin
            @(negedge clock);
            n++;
        end
        if (phase !== p) begin
            checks++;
            errors++;
            $display("FAIL goto_phase: phase=%b want %b", phase, p);
        end
    endtask

    task automatic load_ir(input logic [15:0] v);
        goto_phase(5'b00001);
        mem_data = v;
        @(negedge clock);
        mem_data = 16'h0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        mem_data = 16'h0; ar = 16'h0; br = 16'h0; ext_in = 16'h0;
        #12;
        checks++;
        if ({phase, ir, flags, halted} !== {5'b00001, 16'h0, 4'h0, 1'b0}) begin
            errors++;
            $display("FAIL reset: ph=%b ir=%h fl=%b h=%b", phase, ir, flags, halted);
        end
        @(negedge clock);
        rst_n = 1'b1;
    endtask

    task automatic test_phase_ir();
        logic [4:0] ph = 5'b00001;
        mem_data = 16'hC000;
        checks++;
        if (ir !== 16'h0) begin
            errors++;
            $display("FAIL ir_pre: ir=%h want 0000", ir);
        end
        for (int i = 0; i < 10; i++) begin
            checks++;
            if (phase !== ph) begin
                errors++;
                $display("FAIL phase[%0d]: %b want %b", i, phase, ph);
            end
            @(negedge clock);
            ph = {ph[3:0], ph[4]};
            checks++;
            if (ir !== 16'hC000) begin
                errors++;
                $display("FAIL ir_load[%0d]: ir=%h want C000", i, ir);
            end
        end
        mem_data = 16'h0;
    endtask

    task automatic test_add();
        ar = 16'h7FFF; br = 16'h0001;
        sb.push_back('{16'h8000, 4'b1001});
        load_ir(16'hC000);
        ex = sb.pop_front();
        checks++;
        if ({alu_out, alu_flags} !== {ex.val, ex.flg}) begin
            errors++;
            $display("FAIL add: %h/%b want %h/%b", alu_out, alu_flags, ex.val, ex.flg);
        end
        goto_phase(5'b01000);
        flag_m = ex.flg;
        checks++;
        if (flags !== flag_m) begin
            errors++;
            $display("FAIL add_flags: %b want %b", flags, flag_m);
        end
    endtask

    task automatic test_cmp_hold();
        ar = 16'h0003; br = 16'h0005;
        sb.push_back('{16'hFFFE, 4'b0101});
        load_ir(16'hC050);
        ex = sb.pop_front();
        checks++;
        if ({alu_out, alu_flags} !== {ex.val, ex.flg}) begin
            errors++;
            $display("FAIL cmp: %h/%b want %h/%b", alu_out, alu_flags, ex.val, ex.flg);
        end
        goto_phase(5'b01000);
        flag_m = ex.flg;
        checks++;
        if (flags !== flag_m) begin
            errors++;
            $display("FAIL cmp_flags: %b want %b", flags, flag_m);
        end
        load_ir(16'h8000);
        checks++;
        if (alu_out !== 16'h0008) begin
            errors++;
            $display("FAIL ldi_addr: %h want 0008", alu_out);
        end
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (flags !== flag_m) begin
                errors++;
                $display("FAIL ldi_hold[%0d]: %b want %b", i, flags, flag_m);
            end
            @(negedge clock);
        end
    endtask

    task automatic run_vecs(input vec_t v[$]);
        foreach (v[k]) begin
            ar = v[k].a; br = v[k].b; ext_in = v[k].e;
            sb.push_back('{v[k].val, v[k].flg});
            load_ir(v[k].irv);
            ex = sb.pop_front();
            checks++;
            if ({alu_out, alu_flags} !== {ex.val, ex.flg}) begin
                errors++;
                $display("FAIL %s: %h/%b want %h/%b",
                         v[k].nm, alu_out, alu_flags, ex.val, ex.flg);
            end
            goto_phase(5'b01000);
            if (v[k].upd) flag_m = ex.flg;
            checks++;
            if (flags !== flag_m) begin
                errors++;
                $display("FAIL %s_flags: %b want %b", v[k].nm, flags, flag_m);
            end
        end
    endtask

    task automatic test_alu_ops();
        vec_t v[$];
        v.push_back('{"add_c", 16'hC000, 16'hFFFF, 16'h0001, 16'h0, 16'h0000, 4'b0110, 1'b1});
        v.push_back('{"sub_v", 16'hC010, 16'h8000, 16'h0001, 16'h0, 16'h7FFF, 4'b1000, 1'b1});
        v.push_back('{"sub_z", 16'hC010, 16'h1234, 16'h1234, 16'h0, 16'h0000, 4'b0010, 1'b1});
        v.push_back('{"and", 16'hC020, 16'hF0F0, 16'hFF00, 16'h0, 16'hF000, 4'b0001, 1'b1});
        v.push_back('{"in", 16'hC0C0, 16'h0000, 16'h0000, 16'h1234, 16'h1234, 4'b0000, 1'b0});
        v.push_back('{"or", 16'hC030, 16'h00F0, 16'h0F00, 16'h0, 16'h0FF0, 4'b0000, 1'b1});
        v.push_back('{"xor", 16'hC040, 16'hFFFF, 16'hFFFF, 16'h0, 16'h0000, 4'b0010, 1'b1});
        v.push_back('{"out", 16'hC0D0, 16'h1111, 16'h8000, 16'h0, 16'h8000, 4'b0001, 1'b0});
        v.push_back('{"mov", 16'hC060, 16'h0001, 16'h8000, 16'h0, 16'h8000, 4'b0001, 1'b1});
        v.push_back('{"rsvd", 16'hC070, 16'h5555, 16'h5555, 16'h0, 16'h0000, 4'b0010, 1'b0});
        run_vecs(v);
    endtask

    task automatic test_shifts();
        vec_t v[$];
        v.push_back('{"sll1", 16'hC081, 16'h8001, 16'h0, 16'h0, 16'h0002, 4'b0100, 1'b1});
        v.push_back('{"slr1", 16'hC091, 16'h8001, 16'h0, 16'h0, 16'h0003, 4'b0100, 1'b1});
        v.push_back('{"sra4", 16'hC0B4, 16'h8001, 16'h0, 16'h0, 16'hF800, 4'b0001, 1'b1});
        v.push_back('{"srl4", 16'hC0A4, 16'h8008, 16'h0, 16'h0, 16'h0800, 4'b0100, 1'b1});
        v.push_back('{"srl0", 16'hC0A0, 16'h8001, 16'h0, 16'h0, 16'h8001, 4'b0001, 1'b1});
        run_vecs(v);
    endtask

    task automatic test_load_store();
        vec_t v[$];
        v.push_back('{"ld_ea", 16'h0312, 16'h0100, 16'h0012, 16'h0, 16'h0112, 4'b0000, 1'b0});
        v.push_back('{"st_ea", 16'h4312, 16'hFFFF, 16'h0002, 16'h0, 16'h0001, 4'b0000, 1'b0});
        run_vecs(v);
    endtask

    task automatic test_halt_reset();
        logic [4:0] ph;
        load_ir(16'hC0F0);
        checks++;
        if ({alu_out, halted} !== {16'h0, 1'b0}) begin
            errors++;
            $display("FAIL hlt_pre: out=%h h=%b want 0000/0", alu_out, halted);
        end
        goto_phase(5'b01000);
        ph = 5'b01000;
        for (int i = 0; i < 5; i++) begin
            checks++;
            if ({phase, halted, flags} !== {ph, 1'b1, flag_m}) begin
                errors++;
                $display("FAIL halted[%0d]: ph=%b h=%b fl=%b want %b/1/%b",
                         i, phase, halted, flags, ph, flag_m);
            end
            @(negedge clock);
            ph = {ph[3:0], ph[4]};
        end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({phase, ir, flags, halted} !== {5'b00001, 16'h0, 4'h0, 1'b0}) begin
            errors++;
            $display("FAIL async_rst: ph=%b ir=%h fl=%b h=%b", phase, ir, flags, halted);
        end
        @(negedge clock);
        rst_n = 1'b1;
    endtask

    initial begin
        test_reset();
        test_phase_ir();
        test_add();
        test_cmp_hold();
        test_alu_ops();
        test_shifts();
        test_load_store();
        test_halt_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
